// File: rtl/apb2axi_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one CDC FIFO write port between NUM_REQ requesters.
// Beats are tagged {id, last, data}; packets longer than MAX_BEATS are cut short and flagged.
module apb2axi_fifo_wr_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  WIDTH     = 32,
    parameter int  MAX_BEATS = 16,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int OUT_W     = WIDTH + ID_W + 1
) (
    input  logic                     wr_clk,
    input  logic                     wr_reset,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic                     fifo_wr_vld,
    output logic [OUT_W-1:0]         fifo_wr_data,
    input  logic                     fifo_wr_rdy,
    output logic                     grant_vld,
    output logic [ID_W-1:0]          grant_id,
    output logic                     trunc_err
);

    localparam int CNT_W = $clog2(MAX_BEATS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               trunc_q, trunc_d;

    logic [WIDTH-1:0]   req_data_arr [NUM_REQ];
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic               out_free;
    logic               g_vld;
    logic               g_last;
    logic [WIDTH-1:0]   g_data;
    logic               last_eff;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_vld[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign out_free = !out_vld_q || fifo_wr_rdy;
    assign g_vld    = req_vld[grant_q];
    assign g_last   = req_last[grant_q];
    assign g_data   = req_data_arr[grant_q];
    assign last_eff = g_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        out_vld_d  = out_vld_q && !fifo_wr_rdy;
        out_data_d = out_data_q;
        trunc_d    = 1'b0;
        req_rdy    = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                req_rdy[grant_q] = out_free;
                if (g_vld && out_free) begin
                    // A load in the same cycle as a drain keeps out_vld high.
                    out_data_d = {grant_q, last_eff, g_data};
                    out_vld_d  = 1'b1;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_eff) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                        trunc_d  = !g_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            trunc_q    <= trunc_d;
        end
    end

    assign fifo_wr_vld  = out_vld_q;
    assign fifo_wr_data = out_data_q;
    assign grant_vld    = (state_q == LOCKED);
    assign grant_id     = grant_q;
    assign trunc_err    = trunc_q;

endmodule

// File: tb/tb_apb2axi_fifo_wr_arbiter.sv
// Bench for apb2axi_fifo_wr_arbiter: per-requester packet queues drive the DUT and a
// packet-level scoreboard predicts grants, tagged FIFO words, req_rdy and trunc_err.
module tb_apb2axi_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MB  = 16;
    localparam int IDW = 2;
    localparam int OW  = W + IDW + 1;

    logic           wr_clk = 1'b0;
    logic           wr_reset = 1'b1;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           fifo_wr_vld;
    logic [OW-1:0]  fifo_wr_data;
    logic           fifo_wr_rdy;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic           trunc_err;

    apb2axi_fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
        .wr_clk       (wr_clk),
        .wr_reset     (wr_reset),
        .req_vld      (req_vld),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_rdy      (req_rdy),
        .fifo_wr_vld  (fifo_wr_vld),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_rdy  (fifo_wr_rdy),
        .grant_vld    (grant_vld),
        .grant_id     (grant_id),
        .trunc_err    (trunc_err)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
    } beat_t;

    typedef struct {
        logic [OW-1:0] word;
        bit            trunc;
    } exp_t;

    beat_t         beats [N][$];
    exp_t          exp_pkt[$];
    logic [OW-1:0] exp_out[$];
    bit            m_locked;
    int            m_g;
    int            m_rr;
    bit            m_trunc;
    int            n_cmp;
    int            n_err;
    int            vld_pct;
    int            rdy_pct;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input logic [W-1:0] base, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = rnd ? W'($urandom) : base + W'(k);
            b.last = (k == len - 1);
            beats[r].push_back(b);
        end
    endtask

    task automatic reset_model();
        exp_pkt.delete();
        exp_out.delete();
        m_locked = 1'b0;
        m_g      = 0;
        m_rr     = 0;
        m_trunc  = 1'b0;
    endtask

    // Whole packet predicted at grant time: up to the requester's last beat, cut at MB beats.
    task automatic predict(input int g);
        exp_t  e;
        beat_t b;
        bit    lst;
        for (int p = 0; p < beats[g].size(); p++) begin
            b       = beats[g][p];
            lst     = b.last || (p == MB - 1);
            e.word  = {IDW'(g), lst, b.data};
            e.trunc = !b.last && (p == MB - 1);
            exp_pkt.push_back(e);
            if (lst) break;
        end
    endtask

    function automatic bool_any_pending();
        bit pend;
        pend = m_locked || (exp_out.size() > 0);
        for (int i = 0; i < N; i++) begin
            if (beats[i].size() > 0) pend = 1'b1;
        end
        return pend;
    endfunction

    // One clock: drive at negedge, check registered outputs, advance model across the posedge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        bit           out_busy;
        int           idx;
        exp_t         e;
        for (int i = 0; i < N; i++) begin
            if (beats[i].size() > 0 && $urandom_range(1, 100) <= vld_pct) begin
                req_vld[i]         = 1'b1;
                req_data[i*W +: W] = beats[i][0].data;
                req_last[i]        = beats[i][0].last;
            end else begin
                req_vld[i]         = 1'b0;
                req_data[i*W +: W] = W'($urandom);
                req_last[i]        = 1'($urandom_range(0, 1));
            end
        end
        fifo_wr_rdy = ($urandom_range(1, 100) <= rdy_pct);
        #1;
        out_busy = (exp_out.size() > 0);
        check("fifo_wr_vld", 64'(fifo_wr_vld), 64'(out_busy));
        if (out_busy) check("fifo_wr_data", 64'(fifo_wr_data), 64'(exp_out[0]));
        check("grant_vld", 64'(grant_vld), 64'(m_locked));
        if (m_locked) check("grant_id", 64'(grant_id), 64'(m_g));
        check("trunc_err", 64'(trunc_err), 64'(m_trunc));
        exp_rdy = '0;
        if (m_locked && (!out_busy || fifo_wr_rdy)) exp_rdy[m_g] = 1'b1;
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));

        if (out_busy && fifo_wr_rdy) void'(exp_out.pop_front());
        m_trunc = 1'b0;
        if (m_locked) begin
            if (req_vld[m_g] && exp_rdy[m_g] && exp_pkt.size() > 0) begin
                e = exp_pkt.pop_front();
                exp_out.push_back(e.word);
                m_trunc = e.trunc;
                void'(beats[m_g].pop_front());
                if (exp_pkt.size() == 0) begin
                    m_locked = 1'b0;
                    m_rr     = (m_g + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!m_locked && req_vld[idx]) begin
                    m_locked = 1'b1;
                    m_g      = idx;
                    predict(idx);
                end
            end
        end
        @(negedge wr_clk);
    endtask

    task automatic drain(input int budget);
        int c;
        c       = 0;
        vld_pct = 100;
        rdy_pct = 100;
        while (bool_any_pending() && c < budget) begin
            step();
            c++;
        end
        check("drain_done", 64'(bool_any_pending()), 64'(0));
    endtask

    task automatic do_reset();
        wr_reset = 1'b1;
        repeat (2) @(negedge wr_clk);
        wr_reset = 1'b0;
        reset_model();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        req_vld     = '0;
        req_last    = '0;
        req_data    = '0;
        fifo_wr_rdy = 1'b0;
        vld_pct     = 100;
        rdy_pct     = 100;
        reset_model();

        // Reset with every requester valid: everything quiet, then first grant goes to 0.
        for (int i = 0; i < N; i++) add_pkt(i, 1, W'(32'h10 + i), 1'b0);
        req_vld     = '1;
        fifo_wr_rdy = 1'b1;
        repeat (3) @(negedge wr_clk);
        #1;
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_fifo_wr_vld", 64'(fifo_wr_vld), 64'(0));
        check("rst_fifo_wr_data", 64'(fifo_wr_data), 64'(0));
        check("rst_grant_vld", 64'(grant_vld), 64'(0));
        check("rst_trunc_err", 64'(trunc_err), 64'(0));
        @(negedge wr_clk);
        wr_reset = 1'b0;
        reset_model();
        repeat (12) step();

        // Three-beat packet from requester 2 at full throughput.
        add_pkt(2, 3, W'(32'hA0), 1'b0);
        drain(20);

        // Requesters 0, 1, 3 always holding single-beat packets, rr starting at 0.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (beats[0].size() == 0) add_pkt(0, 1, W'(32'hB00 + c), 1'b0);
            if (beats[1].size() == 0) add_pkt(1, 1, W'(32'hB10 + c), 1'b0);
            if (beats[3].size() == 0) add_pkt(3, 1, W'(32'hB30 + c), 1'b0);
            step();
        end
        drain(40);

        // FIFO full for 5 cycles in the middle of a 4-beat packet.
        add_pkt(0, 4, W'(32'hC0), 1'b0);
        repeat (3) step();
        rdy_pct = 0;
        repeat (5) step();
        rdy_pct = 100;
        drain(20);

        // 20-beat packet truncated at 16; remaining 4 beats form a new packet.
        add_pkt(1, 20, W'(32'h500), 1'b0);
        drain(60);

        // Reset while beat 2 is pending in the output register.
        add_pkt(3, 5, W'(32'h600), 1'b0);
        for (int c = 0; c < 10 && !(beats[3].size() == 3 && exp_out.size() > 0); c++) step();
        check("pre_reset_beats_left", 64'(beats[3].size()), 64'(3));
        #2 wr_reset = 1'b1;
        #1;
        check("async_rst_fifo_wr_vld", 64'(fifo_wr_vld), 64'(0));
        check("async_rst_grant_vld", 64'(grant_vld), 64'(0));
        check("async_rst_req_rdy", 64'(req_rdy), 64'(0));
        reset_model();
        repeat (2) @(negedge wr_clk);
        wr_reset = 1'b0;
        drain(30);

        // Randomized traffic with valid gaps and FIFO back-pressure.
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                vld_pct = $urandom_range(50, 100);
                rdy_pct = $urandom_range(30, 100);
            end
            for (int i = 0; i < N; i++) begin
                if (beats[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 4) == 0) add_pkt(i, $urandom_range(15, 22), '0, 1'b1);
                    else add_pkt(i, $urandom_range(1, 6), '0, 1'b1);
                end
            end
            step();
        end
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/apb2axi_fifo_wr_arbiter.md
Name: apb2axi_fifo_wr_arbiter

Overview:
Packet-level round-robin arbiter that shares the single write port of the async CDC FIFO between NUM_REQ requesters in the write clock domain. A grant is locked for a whole packet, from first beat to the beat flagged last. Each accepted beat is tagged with its source ID and a last flag, then sent through a one-entry output register to the FIFO's valid/ready write port. A beat counter enforces MAX_BEATS: an overlong packet is truncated and an error is flagged.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, payload width per beat
MAX_BEATS, 16, maximum beats per packet (2..256)
ID_W (localparam), $clog2(NUM_REQ), source-ID field width
OUT_W (localparam), WIDTH+ID_W+1, FIFO word width = {id, last, data}

Ports:
wr_clk  in  1  write-domain clock; same clock as the FIFO write side
wr_reset  in  1  asynchronous, active-high reset
req_vld  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last-beat flag
req_data  in  NUM_REQ*WIDTH  payloads; requester i occupies [i*WIDTH +: WIDTH]
req_rdy  out  NUM_REQ  per-requester beat accepted
fifo_wr_vld  out  1  to FIFO wr_vld
fifo_wr_data  out  OUT_W  to FIFO wr_data; {grant_id, last, data}
fifo_wr_rdy  in  1  from FIFO wr_rdy (low = full)
grant_vld  out  1  a packet grant is held
grant_id  out  ID_W  index of the held grant
trunc_err  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- Clock and reset: one clock, wr_clk. Reset is asynchronous and active-high. While wr_reset is high:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, out_vld = 0, out_data = 0;
  - all outputs are 0.
- Outputs are driven directly from registers: fifo_wr_vld = out_vld, fifo_wr_data = out_data, grant_vld = (state == LOCKED), grant_id = grant register, trunc_err = registered pulse.
- out_free = !out_vld | fifo_wr_rdy.
- State machine, IDLE:
  - If any req_vld bit is set, pick the first set index found by searching upward from rr_ptr, wrapping at NUM_REQ.
  - Register that index as grant, go to LOCKED, set beat_cnt = 0.
  - No req_rdy is asserted in IDLE, so the first beat is accepted no earlier than the cycle after the grant.
  - If no req_vld is set, stay in IDLE.
- State machine, LOCKED:
  - req_rdy[g] = out_free for the granted index g; every other req_rdy bit is 0.
  - A beat is accepted when req_vld[g] & req_rdy[g]. On accept, out_data is loaded with {g, last_eff, req_data[g]}, out_vld is set, and beat_cnt increments.
  - last_eff = req_last[g] | (beat_cnt == MAX_BEATS-1).
  - If last_eff is set on the accepted beat: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ (wraps NUM_REQ-1 to 0).
  - If the beat was forced last (req_last[g] = 0 but beat_cnt == MAX_BEATS-1): trunc_err pulses high the next cycle. The requester's remaining beats are treated as a new packet in a later arbitration.
- Output register:
  - If fifo_wr_rdy & out_vld and no new load in the same cycle, out_vld clears.
  - A load and a drain in the same cycle keep out_vld = 1 with the new data, so full throughput is one beat per cycle.
  - When fifo_wr_rdy = 0 and out_vld = 1: out_data and out_vld hold, and req_rdy[g] = 0.
- Timing:
  - Minimum latency is 1 cycle from an accepted beat to fifo_wr_vld.
  - There is one idle arbitration cycle between consecutive packets.
- Boundary cases:
  - A single-beat packet (req_last = 1 on the first beat) returns to IDLE after one accept.
  - req_vld[g] dropping mid-packet does not release the grant (no timeout); other requesters wait.
  - req_vld, req_last and req_data of non-granted requesters are ignored.
  - Reset mid-packet discards any partial packet and any pending output beat.

Test Plan:
1. Reset with req_vld = 4'b1111 -> every req_rdy and fifo_wr_vld = 0. First grant after reset release is id 0; grant_vld rises 1 cycle after the release.
2. Requester 2 sends a 3-beat packet, data 0xA0, 0xA1, 0xA2, with fifo_wr_rdy = 1 -> fifo_wr_data = {2, 0, 0xA0}, {2, 0, 0xA1}, {2, 1, 0xA2} on 3 consecutive cycles; after that, state = IDLE and rr_ptr = 3.
3. Requesters 0, 1, 3 hold single-beat packets continuously with rr_ptr = 0 -> grants in order 0, 1, 3, 0. Each grant is separated by exactly one idle cycle.
4. fifo_wr_rdy = 0 for 5 cycles in the middle of a 4-beat packet -> fifo_wr_vld and fifo_wr_data hold constant and req_rdy[g] = 0. Once fifo_wr_rdy returns, the remaining beats continue with no loss or duplication.
5. MAX_BEATS = 16 and requester 1 sends 20 beats, req_last set only on beat 20 -> beat 16 is emitted with last = 1 and trunc_err pulses once. Beats 17..20 then arrive as a separate 4-beat packet under a new grant.
6. Assert wr_reset during beat 2 of a packet while out_vld = 1 -> fifo_wr_vld drops immediately (asynchronous). After release, state = IDLE and rr_ptr = 0, and no stale beat is emitted.
